// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: serial configuration loader for the CLB logic cell.
// Hunts the bitstream for an 8-bit preamble, shifts in a 37-bit frame plus
// an even-parity bit, and commits good frames to the cell's config outputs.

package clb_cfg_loader_pkg;

    localparam int unsigned PRE_W     = 8;
    localparam int unsigned PAYLOAD_W = 37;
    localparam int unsigned CNT_W     = 6;

    localparam logic [PRE_W-1:0] PREAMBLE = 8'hB7;

    // One configuration frame, first received bit in the MSB
    typedef struct packed {
        logic [15:0] mem;
        logic [1:0]  comboption;
        logic [1:0]  mux2sel;
        logic [1:0]  mux3sel;
        logic [1:0]  mux4sel;
        logic [1:0]  mux5sel;
        logic [1:0]  mux6sel;
        logic [5:0]  o2m;
        logic [1:0]  dqmux;
        logic        floporlatch;
    } cfg_frame_t;

    // Cell power-on defaults
    localparam cfg_frame_t CFG_DEFAULT = '{
        mem:         16'h0116,
        comboption:  2'b00,
        mux2sel:     2'b10,
        mux3sel:     2'b10,
        mux4sel:     2'b10,
        mux5sel:     2'b00,
        mux6sel:     2'b00,
        o2m:         6'b000111,
        dqmux:       2'b00,
        floporlatch: 1'b0
    };

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_PARITY = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

endpackage

module clb_cfg_loader
    import clb_cfg_loader_pkg::*;
(
    input  logic        K,
    input  logic        RST,
    input  logic        DIN,
    input  logic        DEN,
    output logic [15:0] MEM,
    output logic [1:0]  COMBOPTION,
    output logic [1:0]  MUX2SEL,
    output logic [1:0]  MUX3SEL,
    output logic [1:0]  MUX4SEL,
    output logic [1:0]  MUX5SEL,
    output logic [1:0]  MUX6SEL,
    output logic [5:0]  O2M,
    output logic [1:0]  DQMUX,
    output logic        FLOPORLATCH,
    output logic        CFG_VALID,
    output logic        DONE,
    output logic        ERR,
    output logic        BUSY
);

    state_t               state;
    state_t               state_nxt;
    logic [PRE_W-1:0]     pre_shift;
    logic [CNT_W-1:0]     bit_cnt;
    logic [PAYLOAD_W-1:0] shadow;
    cfg_frame_t           cfg;
    logic                 cfg_valid;
    logic                 done;
    logic                 err;
    logic                 busy;

    logic [PRE_W-1:0]     pre_cand_c;
    logic                 pre_match_c;
    logic                 last_bit_c;
    logic                 parity_ok_c;
    logic                 hunt_shift_c;
    logic                 load_shift_c;
    logic                 perr_c;
    logic                 commit_c;

    // Candidate preamble window including the bit on DIN this cycle
    assign pre_cand_c  = {pre_shift[PRE_W-2:0], DIN};
    assign pre_match_c = (pre_cand_c == PREAMBLE);
    assign last_bit_c  = (bit_cnt == CNT_W'(PAYLOAD_W - 1));
    // Payload XOR parity bit must be zero
    assign parity_ok_c = ~((^shadow) ^ DIN);

    // State register
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DEN low stalls every state except COMMIT
    always_comb begin
        state_nxt = state;
        case (state)
            ST_HUNT: begin
                if (DEN && pre_match_c) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (DEN && last_bit_c) begin
                    state_nxt = ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (DEN) begin
                    state_nxt = parity_ok_c ? ST_COMMIT : ST_HUNT;
                end
            end
            ST_COMMIT: begin
                state_nxt = ST_HUNT;
            end
            default: begin
                state_nxt = ST_HUNT;
            end
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        hunt_shift_c = 1'b0;
        load_shift_c = 1'b0;
        perr_c       = 1'b0;
        commit_c     = 1'b0;
        case (state)
            ST_HUNT:   hunt_shift_c = DEN;
            ST_LOAD:   load_shift_c = DEN;
            ST_PARITY: perr_c       = DEN & ~parity_ok_c;
            ST_COMMIT: commit_c     = 1'b1;
            default:   ;
        endcase
    end

    // Preamble shifter; held at zero outside HUNT so no overlap carries over
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            pre_shift <= '0;
        end else if (hunt_shift_c) begin
            pre_shift <= pre_match_c ? '0 : pre_cand_c;
        end else if (state != ST_HUNT) begin
            pre_shift <= '0;
        end
    end

    // Payload bit counter, zero on entry to LOAD
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            bit_cnt <= '0;
        end else if (state != ST_LOAD) begin
            bit_cnt <= '0;
        end else if (load_shift_c) begin
            bit_cnt <= bit_cnt + CNT_W'(1);
        end
    end

    // Shadow register collects the frame; 37 shifts fully overwrite it
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            shadow <= '0;
        end else if (load_shift_c) begin
            shadow <= {shadow[PAYLOAD_W-2:0], DIN};
        end
    end

    // Committed configuration, only updated from a parity-checked frame
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            cfg <= CFG_DEFAULT;
        end else if (commit_c) begin
            cfg <= cfg_frame_t'(shadow);
        end
    end

    // Status flags
    always_ff @(posedge K or posedge RST) begin
        if (RST) begin
            cfg_valid <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
        end else begin
            done <= commit_c;
            busy <= (state_nxt != ST_HUNT);
            if (commit_c) begin
                cfg_valid <= 1'b1;
                err       <= 1'b0;
            end else if (perr_c) begin
                err <= 1'b1;
            end
        end
    end

    assign MEM         = cfg.mem;
    assign COMBOPTION  = cfg.comboption;
    assign MUX2SEL     = cfg.mux2sel;
    assign MUX3SEL     = cfg.mux3sel;
    assign MUX4SEL     = cfg.mux4sel;
    assign MUX5SEL     = cfg.mux5sel;
    assign MUX6SEL     = cfg.mux6sel;
    assign O2M         = cfg.o2m;
    assign DQMUX       = cfg.dqmux;
    assign FLOPORLATCH = cfg.floporlatch;
    assign CFG_VALID   = cfg_valid;
    assign DONE        = done;
    assign ERR         = err;
    assign BUSY        = busy;

endmodule
